pixel_stream_sink: RTL and testbench
====================================

Name: pixel_stream_sink

Overview:
Receiving end of the pixel-generator stream protocol: valid/ready handshake, 24-bit colour, first/last_x/last_y framing flags. It accepts beats, rebuilds x/y coordinates from the framing, checks framing against the configured screen size, and buffers tagged pixels in a small FIFO for the downstream display/framebuffer writer. It sits between the pixel stream and the VGA/framebuffer write path.

Parameters:
COORD_WIDTH, 32, width of out_x/out_y and internal counters
RGB_SIZE, 24, colour width
SCREEN_WIDTH, 640, pixels per line
SCREEN_HEIGHT, 480, lines per frame
FIFO_DEPTH, 4, output FIFO entries, power of two, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream beat valid
in_ready  out  1  sink can accept a beat
in_colour  in  RGB_SIZE  pixel colour
in_first  in  1  first pixel of frame (SOF)
in_last_x  in  1  last pixel of line (EOL)
in_last_y  in  1  last pixel of frame (EOF), valid only with in_last_x
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream pops the head
out_colour  out  RGB_SIZE  head colour
out_x  out  COORD_WIDTH  head x coordinate
out_y  out  COORD_WIDTH  head y coordinate
out_eof  out  1  head is the final pixel of the frame
frame_done  out  1  one-cycle pulse when a frame's final pixel is accepted
frame_count  out  16  completed frames, wraps at 65535->0
err_sof  out  1  sticky: SOF arrived mid-frame
err_eol  out  1  sticky: EOL early or missing
err_eof  out  1  sticky: EOF misplaced or missing

Behaviour:
- Reset: state=WAIT_SOF, x=y=0, FIFO empty, out_valid=0, in_ready=1, frame_done=0, frame_count=0, all err_*=0. out_colour/x/y/eof are don't-care while out_valid=0. Reset mid-frame discards FIFO contents and the partial frame.
- Accept = in_valid && in_ready. in_ready = !fifo_full. Push and pop in the same cycle are allowed when not full. When full, no push even if popping, so in_ready has no combinational path from out_ready.
- FSM WAIT_SOF: every accepted beat with in_first=0 is discarded and not written. An accepted beat with in_first=1 is written as (0,0) and moves the FSM to ACTIVE with x=1, y=0. If that beat also ends the line or frame, the ACTIVE rules below apply to it.
- FSM ACTIVE, per accepted beat at current (x,y):
  - in_first=1: set err_sof, treat the beat as a new (0,0), write it, x=1, y=0.
  - EOL is expected when x==SCREEN_WIDTH-1.
    - in_last_x at x<W-1: set err_eol, then x=0, y+1.
    - No in_last_x at x==W-1: set err_eol and force end of line.
    - Otherwise, at end of line: x=0, y+1.
  - Final pixel is x==W-1 and y==H-1.
    - in_last_y missing at the final pixel, or present anywhere else: set err_eof.
    - The final pixel is always written with out_eof=1, pulses frame_done the next cycle, increments frame_count, and returns the FSM to WAIT_SOF.
  - A forced line advance past y==H-1 cannot occur: the final-pixel rule takes priority.
- Latency: an accepted beat is visible at out_valid on the following clock edge. The FIFO is registered with fall-through to head.
- Error flags are sticky until reset. Arithmetic is unsigned; counters never exceed W-1 or H-1.

Optional Feature:
PIXEL_SINK_CHECK_EN
- Defined: framing checks, error flags, and the SOF-resync behaviour are as above.
- Undefined: err_* are tied to 0, and in_first in ACTIVE is ignored.
  - in_last_x and in_last_y are ignored.
  - Coordinates advance purely by count: wrap at W-1, frame ends at (W-1,H-1).
  - The WAIT_SOF gating on in_first remains.

Decomposition:
- Shared package pixel_stream_pkg:
  - SCREEN_WIDTH/SCREEN_HEIGHT/RGB_SIZE defaults.
  - typedef pixel_beat_t {colour, first, last_x, last_y}.
  - typedef tagged_pixel_t {colour, x, y, eof}.
  - enum sink_state_e {WAIT_SOF, ACTIVE}.
- Sub-module pixel_fifo: parameterised on tagged_pixel_t and FIFO_DEPTH, with push/pop/full/empty, synchronous reset.

Test Plan (W=4, H=2, FIFO_DEPTH=4, macro defined):
1. Clean frame: 8 beats, first on beat0, last_x on beats 3 and 7, last_y on beat7, out_ready=1 -> outputs (0,0)..(3,1) in order; out_eof only on (3,1); frame_done pulses once; frame_count=1; err_*=0.
2. Pre-SOF garbage: 3 beats with first=0, then a clean frame -> garbage is dropped; the first output is (0,0); in_ready=1 throughout.
3. Backpressure: out_ready=0 while 6 beats are offered -> in_ready falls after 4 accepted; release out_ready -> all 8 pixels emerge in order with no loss or duplication.
4. Early EOL: last_x at x=1 of line 0 -> err_eol=1; next beat is tagged (0,1).
5. Mid-frame SOF: first=1 at (2,0) -> err_sof=1; that beat is output as (0,0); frame completes normally after 7 more beats.
6. Missing last_y on the final pixel -> err_eof=1; frame_done still pulses; reset mid-frame -> FIFO empty, out_valid=0, err_* cleared.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types and defaults for the pixel stream protocol (source and sink sides).
package pixel_stream_pkg;

    localparam int DEFAULT_SCREEN_WIDTH  = 640;
    localparam int DEFAULT_SCREEN_HEIGHT = 480;
    localparam int DEFAULT_RGB_SIZE      = 24;
    localparam int DEFAULT_COORD_WIDTH   = 32;

    typedef struct packed {
        logic [DEFAULT_RGB_SIZE-1:0] colour;
        logic                        first;
        logic                        last_x;
        logic                        last_y;
    } pixel_beat_t;

    typedef struct packed {
        logic [DEFAULT_RGB_SIZE-1:0]    colour;
        logic [DEFAULT_COORD_WIDTH-1:0] x;
        logic [DEFAULT_COORD_WIDTH-1:0] y;
        logic                           eof;
    } tagged_pixel_t;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } sink_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Small registered FIFO with fall-through head; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module pixel_fifo
    import pixel_stream_pkg::*;
#(
    parameter type entry_t    = tagged_pixel_t,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    entry_t        mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pixel_stream_sink.sv
// Pixel stream receiver: rebuilds x/y from framing flags and queues tagged pixels.
// Framing checks and error flags are built only when PIXEL_SINK_CHECK_EN is defined.
module pixel_stream_sink
    import pixel_stream_pkg::*;
#(
    parameter int COORD_WIDTH   = 32,
    parameter int RGB_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RGB_SIZE-1:0]    in_colour,
    input  logic                   in_first,
    input  logic                   in_last_x,
    input  logic                   in_last_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RGB_SIZE-1:0]    out_colour,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic                   out_eof,
    output logic                   frame_done,
    output logic [15:0]            frame_count,
    output logic                   err_sof,
    output logic                   err_eol,
    output logic                   err_eof
);

    typedef struct packed {
        logic [RGB_SIZE-1:0]    colour;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic                   eof;
    } entry_t;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(SCREEN_HEIGHT - 1);

    sink_state_e            state_q, state_d;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                   frame_done_q, frame_done_d;
    logic [15:0]            frame_count_q, frame_count_d;

    logic                   fifo_full, fifo_empty, accept, write_beat;
    logic                   restart, at_eol, at_final;
    logic [COORD_WIDTH-1:0] cur_x, cur_y;
    logic                   sof_resync, eol_mark;
    entry_t                 wr_entry, head;

    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign write_beat = accept && (state_q == ACTIVE || in_first);

`ifdef PIXEL_SINK_CHECK_EN
    assign sof_resync = in_first;
    assign eol_mark   = in_last_x;
`else
    logic unused_framing;
    assign sof_resync     = 1'b0;
    assign eol_mark       = 1'b0;
    assign unused_framing = ^{in_last_x, in_last_y};
`endif

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        restart       = (state_q == WAIT_SOF) || sof_resync;
        cur_x         = restart ? '0 : x_q;
        cur_y         = restart ? '0 : y_q;
        at_eol        = (cur_x == X_LAST);
        at_final      = at_eol && (cur_y == Y_LAST);
        wr_entry      = '{colour: in_colour, x: cur_x, y: cur_y, eof: at_final};
        if (write_beat) begin
            if (at_final) begin
                state_d       = WAIT_SOF;
                x_d           = '0;
                y_d           = '0;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end else if (at_eol || eol_mark) begin
                // An early EOL on the last line restarts that line rather than overrunning the frame.
                state_d = ACTIVE;
                x_d     = '0;
                y_d     = (cur_y == Y_LAST) ? cur_y : cur_y + 1'b1;
            end else begin
                state_d = ACTIVE;
                x_d     = cur_x + 1'b1;
                y_d     = cur_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_SOF;
            x_q           <= '0;
            y_q           <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef PIXEL_SINK_CHECK_EN
    logic err_sof_q, err_sof_d, err_eol_q, err_eol_d, err_eof_q, err_eof_d;

    always_comb begin
        err_sof_d = err_sof_q | (write_beat && state_q == ACTIVE && in_first);
        err_eol_d = err_eol_q | (write_beat && (in_last_x != at_eol));
        err_eof_d = err_eof_q | (write_beat && (in_last_y != at_final));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sof_q <= 1'b0;
            err_eol_q <= 1'b0;
            err_eof_q <= 1'b0;
        end else begin
            err_sof_q <= err_sof_d;
            err_eol_q <= err_eol_d;
            err_eof_q <= err_eof_d;
        end
    end

    assign err_sof = err_sof_q;
    assign err_eol = err_eol_q;
    assign err_eof = err_eof_q;
`else
    assign err_sof = 1'b0;
    assign err_eol = 1'b0;
    assign err_eof = 1'b0;
`endif

    pixel_fifo #(
        .entry_t    (entry_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (write_beat),
        .push_data (wr_entry),
        .pop       (out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_colour  = head.colour;
    assign out_x       = head.x;
    assign out_y       = head.y;
    assign out_eof     = head.eof;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Randomized and directed bench for pixel_stream_sink on a 4x2 screen with a 4-entry FIFO.
module tb_pixel_stream_sink;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 32;
    localparam int RGB   = 24;
`ifdef PIXEL_SINK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [RGB-1:0] in_colour = '0;
    logic           in_first = 1'b0;
    logic           in_last_x = 1'b0;
    logic           in_last_y = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [RGB-1:0] out_colour;
    logic [CW-1:0]  out_x, out_y;
    logic           out_eof, frame_done;
    logic [15:0]    frame_count;
    logic           err_sof, err_eol, err_eof;

    pixel_stream_sink #(
        .COORD_WIDTH(CW), .RGB_SIZE(RGB), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_colour(in_colour), .in_first(in_first), .in_last_x(in_last_x), .in_last_y(in_last_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_colour(out_colour),
        .out_x(out_x), .out_y(out_y), .out_eof(out_eof), .frame_done(frame_done),
        .frame_count(frame_count), .err_sof(err_sof), .err_eol(err_eol), .err_eof(err_eof)
    );

    initial forever #5 clk = ~clk;

    // Reference model: a linear pixel index within the frame plus a queue of expected outputs.
    typedef struct {
        int colour;
        int x;
        int y;
        bit eof;
    } exp_t;

    exp_t q[$];
    bit   in_frame;
    int   pos;
    int   frames;
    bit   e_sof, e_eol, e_eof;
    bit   fd_pending, exp_fd;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("in_ready", in_ready, q.size() < DEPTH);
        check_val("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_val("out_colour", out_colour, q[0].colour);
            check_val("out_x", out_x, q[0].x);
            check_val("out_y", out_y, q[0].y);
            check_val("out_eof", out_eof, q[0].eof);
        end
        check_val("frame_done", frame_done, exp_fd);
        check_val("frame_count", frame_count, frames & 16'hFFFF);
        check_val("err_sof", err_sof, e_sof);
        check_val("err_eol", err_eol, e_eol);
        check_val("err_eof", err_eof, e_eof);
    endtask

    function automatic void model_accept(input int c, input bit f, input bit lx, input bit ly);
        int x, y;
        bit fin;
        if (!in_frame && !f) return;
        if (in_frame && CHK && f) e_sof = 1'b1;
        if (!in_frame || (CHK && f)) begin
            pos      = 0;
            in_frame = 1'b1;
        end
        x   = pos % W;
        y   = pos / W;
        fin = (pos == W * H - 1);
        q.push_back('{colour: c, x: x, y: y, eof: fin});
        if (CHK && (lx != (x == W - 1))) e_eol = 1'b1;
        if (CHK && (ly != fin)) e_eof = 1'b1;
        if (fin) begin
            in_frame   = 1'b0;
            frames++;
            fd_pending = 1'b1;
        end else if (CHK && lx && x != W - 1) begin
            pos = (y == H - 1) ? y * W : (y + 1) * W;
        end else begin
            pos++;
        end
    endfunction

    task automatic cycle(input bit v, input logic [RGB-1:0] c, input bit f, input bit lx,
                         input bit ly, input bit ordy, output bit acc);
        bit pop;
        check_outputs();
        in_valid   = v;
        in_colour  = c;
        in_first   = f;
        in_last_x  = lx;
        in_last_y  = ly;
        out_ready  = ordy;
        acc        = v && (q.size() < DEPTH);
        pop        = ordy && (q.size() != 0);
        fd_pending = 1'b0;
        if (pop) void'(q.pop_front());
        if (acc) model_accept(int'(c), f, lx, ly);
        @(posedge clk);
        #1;
        exp_fd = fd_pending;
    endtask

    function automatic void good_flags(output bit f, output bit lx, output bit ly);
        int p;
        p  = in_frame ? pos : 0;
        f  = !in_frame;
        lx = (p % W) == W - 1;
        ly = (p == W * H - 1);
    endfunction

    task automatic push_beat(input bit f, input bit lx, input bit ly, input bit ordy);
        bit acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, RGB'($urandom), f, lx, ly, ordy, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) check_val("push_timeout", 0, 1);
    endtask

    task automatic good_beat(input bit ordy);
        bit f, lx, ly;
        good_flags(f, lx, ly);
        push_beat(f, lx, ly, ordy);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while (in_frame && n < 40) begin
            good_beat(1'b1);
            n++;
        end
        if (in_frame) check_val("frame_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        q.delete();
        in_frame = 1'b0;
        pos      = 0;
        frames   = 0;
        e_sof    = 1'b0;
        e_eol    = 1'b0;
        e_eof    = 1'b0;
        exp_fd   = 1'b0;
    endtask

    initial begin
        bit acc, f, lx, ly;
        do_reset();
        check_outputs();

        // clean frame
        for (int i = 0; i < W * H; i++) good_beat(1'b1);
        idle(3);
        check_val("t1_frame_count", frame_count, 16'd1);

        // garbage before SOF, then a clean frame
        for (int i = 0; i < 3; i++) cycle(1'b1, RGB'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, acc);
        for (int i = 0; i < W * H; i++) good_beat(1'b1);
        idle(3);

        // backpressure until the FIFO fills, then drain
        for (int i = 0; i < 6; i++) begin
            good_flags(f, lx, ly);
            cycle(1'b1, RGB'($urandom), f, lx, ly, 1'b0, acc);
        end
        check_val("t3_in_ready_full", in_ready, 1'b0);
        finish_frame();
        idle(6);

        // early EOL at x=1 on line 0
        do_reset();
        good_beat(1'b1);
        push_beat(1'b0, 1'b1, 1'b0, 1'b1);
        finish_frame();
        idle(4);

        // SOF in the middle of a line
        good_beat(1'b1);
        good_beat(1'b1);
        push_beat(1'b1, 1'b0, 1'b0, 1'b1);
        finish_frame();
        idle(4);

        // missing last_y on the final pixel, then reset mid-frame
        for (int i = 0; i < W * H - 1; i++) good_beat(1'b1);
        push_beat(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) good_beat(1'b0);
        do_reset();
        check_outputs();
        check_val("t6_out_valid_after_reset", out_valid, 1'b0);

        // random traffic with occasional framing faults
        for (int i = 0; i < 400; i++) begin
            good_flags(f, lx, ly);
            if ($urandom_range(0, 9) == 0) begin
                f  = $urandom_range(0, 1) == 1;
                lx = $urandom_range(0, 1) == 1;
                ly = $urandom_range(0, 1) == 1;
            end
            cycle($urandom_range(0, 3) != 0, RGB'($urandom), f, lx, ly,
                  $urandom_range(0, 4) < 3, acc);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
